// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the LC-3b memory-port arbiter.
package mem_port_arbiter_pkg;

   typedef logic [15:0]  lc3b_word;
   typedef logic [127:0] lc3b_data;
   typedef logic [15:0]  lc3b_mem_wmask;

   typedef enum logic [1:0] {
      ARB_IDLE    = 2'd0,
      ARB_GRANT_I = 2'd1,
      ARB_GRANT_D = 2'd2
   } lc3b_arb_state;

   // Side identifiers: also the bit positions inside the one-hot grant vector.
   localparam logic ARB_SEL_I = 1'b0;
   localparam logic ARB_SEL_D = 1'b1;

   // Beat counter width; a disabled limit still needs one bit to keep widths legal.
   function automatic int beat_cnt_w(input int max_beats);
      return (max_beats > 0) ? $clog2(max_beats + 1) : 1;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_beat_counter.sv
// Saturating count of completed beats taken by the current holder.
module arb_beat_counter
   import mem_port_arbiter_pkg::*;
#(
   parameter int MAX_BEATS = 4,
   parameter int CNT_W     = beat_cnt_w(MAX_BEATS)
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic inc,
   output logic at_limit
);

   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_BEATS);

   logic [CNT_W-1:0] count;
   logic [CNT_W:0]   next_val;

   // One extra bit so count+1 cannot wrap before the unsigned compare.
   assign next_val = {1'b0, count} + {{CNT_W{1'b0}}, 1'b1};
   assign at_limit = (MAX_BEATS != 0) && (next_val >= {1'b0, LIMIT});

   // Clear takes priority over increment; the count holds once it reaches the limit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (inc && (count != LIMIT)) begin
         count <= next_val[CNT_W-1:0];
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory line port between the I-cache and D-cache miss paths.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int LINE_W    = 128,
   parameter int ADDR_W    = 16,
   parameter int MAX_BEATS = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_cyc,
   input  logic                  i_stb,
   input  logic                  i_we,
   input  logic [LINE_W/8-1:0]   i_sel,
   input  logic [ADDR_W-1:0]     i_addr,
   input  logic [LINE_W-1:0]     i_wdata,
   output logic [LINE_W-1:0]     i_rdata,
   output logic                  i_resp,
   output logic                  i_retry,
   input  logic                  d_cyc,
   input  logic                  d_stb,
   input  logic                  d_we,
   input  logic [LINE_W/8-1:0]   d_sel,
   input  logic [ADDR_W-1:0]     d_addr,
   input  logic [LINE_W-1:0]     d_wdata,
   output logic [LINE_W-1:0]     d_rdata,
   output logic                  d_resp,
   output logic                  d_retry,
   output logic                  m_cyc,
   output logic                  m_stb,
   output logic                  m_we,
   output logic [LINE_W/8-1:0]   m_sel,
   output logic [ADDR_W-1:0]     m_addr,
   output logic [LINE_W-1:0]     m_wdata,
   input  logic [LINE_W-1:0]     m_rdata,
   input  logic                  m_resp,
   input  logic                  m_retry,
   output logic [1:0]            grant,
   output logic                  busy
);

   lc3b_arb_state state_q, state_d;
   logic          last_grant_q, last_grant_d;
   logic          outstanding_q, outstanding_d;
   logic          stale_q, stale_d;
   logic          i_req, d_req;
   logic          resp_eff;
   logic          rel;
   logic          beat_inc;
   logic          at_limit;

   assign i_req    = i_cyc & i_stb;
   assign d_req    = d_cyc & d_stb;
   // A response owed to a holder that already walked away must not reach the new holder.
   assign resp_eff = m_resp & ~stale_q;
   assign i_rdata  = m_rdata;
   assign d_rdata  = m_rdata;

   arb_beat_counter #(
      .MAX_BEATS (MAX_BEATS)
   ) u_beat (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (rel),
      .inc      (beat_inc),
      .at_limit (at_limit)
   );

   // State, last owner and stale-response tracking; reset abandons any transfer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ARB_IDLE;
         last_grant_q  <= ARB_SEL_I;
         outstanding_q <= 1'b0;
         stale_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         last_grant_q  <= last_grant_d;
         outstanding_q <= outstanding_d;
         stale_q       <= stale_d;
      end
   end

   // Next-state arbitration, release decision and port muxing for the current owner.
   always_comb begin
      state_d       = state_q;
      last_grant_d  = last_grant_q;
      outstanding_d = 1'b0;
      stale_d       = (m_resp | m_retry) ? 1'b0 : stale_q;
      rel           = 1'b0;
      beat_inc      = 1'b0;
      m_cyc         = 1'b0;
      m_stb         = 1'b0;
      m_we          = 1'b0;
      m_sel         = '0;
      m_addr        = '0;
      m_wdata       = '0;
      i_resp        = 1'b0;
      i_retry       = 1'b0;
      d_resp        = 1'b0;
      d_retry       = 1'b0;
      grant         = 2'b00;
      busy          = 1'b0;

      unique case (state_q)
         ARB_IDLE: begin
            if (i_req && d_req) begin
               state_d = (last_grant_q == ARB_SEL_I) ? ARB_GRANT_D : ARB_GRANT_I;
            end else if (i_req) begin
               state_d = ARB_GRANT_I;
            end else if (d_req) begin
               state_d = ARB_GRANT_D;
            end
         end

         ARB_GRANT_I: begin
            m_cyc            = i_cyc;
            m_stb            = i_stb;
            m_we             = i_we;
            m_sel            = i_sel;
            m_addr           = i_addr;
            m_wdata          = i_wdata;
            i_resp           = resp_eff;
            i_retry          = m_retry & ~m_resp & ~stale_q;
            grant[ARB_SEL_I] = 1'b1;
            busy             = 1'b1;
            beat_inc         = resp_eff;
            outstanding_d    = i_cyc & i_stb & ~m_resp & ~m_retry;
            rel              = ~i_cyc | (resp_eff & at_limit & d_req);
            if (rel) begin
               last_grant_d = ARB_SEL_I;
               state_d      = d_req ? ARB_GRANT_D : ARB_IDLE;
               if (!i_cyc && outstanding_q && !m_resp && !m_retry) begin
                  stale_d = 1'b1;
               end
            end
         end

         ARB_GRANT_D: begin
            m_cyc            = d_cyc;
            m_stb            = d_stb;
            m_we             = d_we;
            m_sel            = d_sel;
            m_addr           = d_addr;
            m_wdata          = d_wdata;
            d_resp           = resp_eff;
            d_retry          = m_retry & ~m_resp & ~stale_q;
            grant[ARB_SEL_D] = 1'b1;
            busy             = 1'b1;
            beat_inc         = resp_eff;
            outstanding_d    = d_cyc & d_stb & ~m_resp & ~m_retry;
            rel              = ~d_cyc | (resp_eff & at_limit & i_req);
            if (rel) begin
               last_grant_d = ARB_SEL_D;
               state_d      = i_req ? ARB_GRANT_I : ARB_IDLE;
               if (!d_cyc && outstanding_q && !m_resp && !m_retry) begin
                  stale_d = 1'b1;
               end
            end
         end

         default: begin
            state_d = ARB_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scoreboard bench for mem_port_arbiter (MAX_BEATS=4 and MAX_BEATS=0 instances).
module tb_mem_port_arbiter;

   localparam int LINE_W = 128;
   localparam int ADDR_W = 16;
   localparam int SEL_W  = LINE_W / 8;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              i_cyc, i_stb, i_we, d_cyc, d_stb, d_we;
   logic [SEL_W-1:0]  i_sel, d_sel;
   logic [ADDR_W-1:0] i_addr, d_addr;
   logic [LINE_W-1:0] i_wdata, d_wdata, m_rdata;
   logic              m_resp, m_retry;

   logic [LINE_W-1:0] i_rdata, d_rdata, z_i_rdata, z_d_rdata;
   logic              i_resp, i_retry, d_resp, d_retry;
   logic              z_i_resp, z_i_retry, z_d_resp, z_d_retry;
   logic              m_cyc, m_stb, m_we, z_m_cyc, z_m_stb, z_m_we;
   logic [SEL_W-1:0]  m_sel, z_m_sel;
   logic [ADDR_W-1:0] m_addr, z_m_addr;
   logic [LINE_W-1:0] m_wdata, z_m_wdata;
   logic [1:0]        grant, z_grant;
   logic              busy, z_busy;

   typedef struct {
      bit                side;
      logic [LINE_W-1:0] data;
   } exp_t;

   exp_t q[$];
   int   errors = 0;
   int   checks = 0;
   bit   mon_en = 1'b0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W), .MAX_BEATS(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_cyc(i_cyc), .i_stb(i_stb), .i_we(i_we), .i_sel(i_sel), .i_addr(i_addr),
      .i_wdata(i_wdata), .i_rdata(i_rdata), .i_resp(i_resp), .i_retry(i_retry),
      .d_cyc(d_cyc), .d_stb(d_stb), .d_we(d_we), .d_sel(d_sel), .d_addr(d_addr),
      .d_wdata(d_wdata), .d_rdata(d_rdata), .d_resp(d_resp), .d_retry(d_retry),
      .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_sel(m_sel), .m_addr(m_addr),
      .m_wdata(m_wdata), .m_rdata(m_rdata), .m_resp(m_resp), .m_retry(m_retry),
      .grant(grant), .busy(busy)
   );

   mem_port_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W), .MAX_BEATS(0)) dut0 (
      .clk(clk), .rst_n(rst_n),
      .i_cyc(i_cyc), .i_stb(i_stb), .i_we(i_we), .i_sel(i_sel), .i_addr(i_addr),
      .i_wdata(i_wdata), .i_rdata(z_i_rdata), .i_resp(z_i_resp), .i_retry(z_i_retry),
      .d_cyc(d_cyc), .d_stb(d_stb), .d_we(d_we), .d_sel(d_sel), .d_addr(d_addr),
      .d_wdata(d_wdata), .d_rdata(z_d_rdata), .d_resp(z_d_resp), .d_retry(z_d_retry),
      .m_cyc(z_m_cyc), .m_stb(z_m_stb), .m_we(z_m_we), .m_sel(z_m_sel), .m_addr(z_m_addr),
      .m_wdata(z_m_wdata), .m_rdata(m_rdata), .m_resp(m_resp), .m_retry(m_retry),
      .grant(z_grant), .busy(z_busy)
   );

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input bit side, input logic [LINE_W-1:0] data);
      exp_t e;
      e.side  = side;
      e.data  = data;
      m_rdata = data;
      m_resp  = 1'b1;
      q.push_back(e);
   endtask

   // Monitor: every response presented by the MAX_BEATS=4 instance is popped and compared.
   initial begin
      exp_t        e;
      logic [127:0] got;
      forever begin
         @(negedge clk);
         if (mon_en && rst_n && (i_resp || d_resp)) begin
            checks++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_resp: got i_resp=%0b d_resp=%0b expected no response", i_resp, d_resp);
            end else begin
               e   = q.pop_front();
               got = e.side ? d_rdata : i_rdata;
               if ((i_resp && d_resp) || (d_resp != e.side) || (got !== e.data)) begin
                  errors++;
                  $display("FAIL resp_match: got side=%0d i_resp=%0b d_resp=%0b data=%h expected side=%0d data=%h",
                           d_resp, i_resp, d_resp, got, e.side, e.data);
               end
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      i_cyc = 0; i_stb = 0; i_we = 0; i_sel = '1; i_addr = '0; i_wdata = '0;
      d_cyc = 0; d_stb = 0; d_we = 0; d_sel = '1; d_addr = '0; d_wdata = '0;
      m_rdata = '0; m_resp = 0; m_retry = 0;

      // Reset state
      #12;
      chk("reset_grant", grant, 2'b00);
      chk("reset_busy", busy, 1'b0);
      chk("reset_m_cyc", m_cyc, 1'b0);
      @(posedge clk); #1;
      rst_n  = 1'b1;
      mon_en = 1'b1;

      // Single I request
      i_cyc = 1; i_stb = 1; i_addr = 16'h1230;
      #1;
      chk("idle_latency", grant, 2'b00);
      tick();
      chk("single_grant", grant, 2'b01);
      chk("single_addr", m_addr, 16'h1230);
      chk("single_busy", busy, 1'b1);
      beat(1'b0, {16{8'hA5}});
      @(negedge clk);
      chk("single_d_resp", d_resp, 1'b0);
      tick();
      m_resp = 0; i_cyc = 0; i_stb = 0;
      tick();
      chk("release_idle", grant, 2'b00);

      // Tie: D wins (last_grant=I), then hand-off with no idle cycle
      i_cyc = 1; i_stb = 1;
      d_cyc = 1; d_stb = 1; d_addr = 16'h4560;
      tick();
      chk("tie_d", grant, 2'b10);
      chk("tie_addr", m_addr, 16'h4560);
      d_cyc = 0; d_stb = 0;
      tick();
      chk("handoff_no_idle", grant, 2'b01);
      chk("handoff_addr", m_addr, 16'h1230);

      // Preemption after 4 beats while I waits
      i_cyc = 0; i_stb = 0;
      tick();
      chk("to_idle", grant, 2'b00);
      d_cyc = 1; d_stb = 1;
      tick();
      i_cyc = 1; i_stb = 1;
      for (int k = 1; k <= 4; k++) begin
         beat(1'b1, {8{16'(k)}});
         tick();
         chk((k < 4) ? "preempt_hold" : "preempt_switch", grant, (k < 4) ? 2'b10 : 2'b01);
      end
      m_resp = 0;
      chk("preempt_cnt_clear", dut.u_beat.count, 3'd0);

      // I idle: D streams past the limit, counter saturates
      i_cyc = 0; i_stb = 0;
      tick();
      chk("d_regrant", grant, 2'b10);
      for (int k = 1; k <= 6; k++) begin
         beat(1'b1, {8{16'(16'h100 + k)}});
         tick();
      end
      m_resp = 0;
      chk("no_preempt_alone", grant, 2'b10);
      chk("saturate", dut.u_beat.count, 3'd4);
      d_cyc = 0; d_stb = 0;
      tick();

      // Retry handling
      d_cyc = 1; d_stb = 1;
      tick();
      m_retry = 1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("retry_d", d_retry, 1'b1);
         chk("retry_grant", grant, 2'b10);
         tick();
      end
      m_retry = 0;
      beat(1'b1, {16{8'h3C}});
      @(negedge clk);
      chk("retry_done", d_retry, 1'b0);
      tick();
      m_resp = 0;
      chk("retry_no_count", dut.u_beat.count, 3'd1);
      beat(1'b1, {16{8'h5A}});
      m_retry = 1;
      @(negedge clk);
      chk("resp_wins", d_retry, 1'b0);
      tick();
      m_resp = 0; m_retry = 0;
      chk("resp_wins_cnt", dut.u_beat.count, 3'd2);

      // Async reset mid-transfer
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_m_cyc", m_cyc, 1'b0);
      chk("async_m_stb", m_stb, 1'b0);
      chk("async_grant", grant, 2'b00);
      chk("async_busy", busy, 1'b0);
      i_cyc = 1; i_stb = 1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      tick();
      chk("reset_tie_d", grant, 2'b10);

      // MAX_BEATS=0 instance: no preemption
      mon_en = 1'b0;
      rst_n  = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      chk("mb0_grant", z_grant, 2'b10);
      for (int k = 1; k <= 10; k++) begin
         m_rdata = {8{16'(k)}};
         m_resp  = 1;
         tick();
         chk("mb0_hold", z_grant, 2'b10);
      end
      m_resp = 0;
      d_cyc = 0; d_stb = 0;
      tick();
      chk("mb0_release", z_grant, 2'b01);
      chk("scoreboard_drained", q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one physical-memory/L2 line port between the instruction-cache miss path and the data-cache miss path of the pipelined LC-3b core.
- Sits between the two cache miss interfaces and the single memory port.
- Grants whole-cycle (cyc-held) ownership to one side at a time, using round-robin on ties.
- Forces a hand-off after a programmable number of completed line beats, so a streaming D-side cannot starve fetch.

Parameters:
- LINE_W, 128, line data width (lc3b_data)
- ADDR_W, 16, address width (lc3b_word)
- MAX_BEATS, 4, completed responses a holder may take while the other side waits; 0 disables preemption

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- i_cyc  in  1  I-side bus cycle active
- i_stb  in  1  I-side request strobe
- i_we  in  1  I-side write
- i_sel  in  LINE_W/8  I-side byte enable (lc3b_mem_wmask)
- i_addr  in  ADDR_W  I-side line address
- i_wdata  in  LINE_W  I-side write line
- i_rdata  out  LINE_W  read line to I-side
- i_resp  out  1  I-side transfer complete
- i_retry  out  1  I-side re-issue request
- d_cyc, d_stb, d_we, d_sel, d_addr, d_wdata, d_rdata, d_resp, d_retry: same as i_*, D-side
- m_cyc  out  1  memory cycle
- m_stb  out  1  memory strobe
- m_we  out  1  memory write
- m_sel  out  LINE_W/8  memory byte enable
- m_addr  out  ADDR_W  memory address
- m_wdata  out  LINE_W  memory write line
- m_rdata  in  LINE_W  memory read line
- m_resp  in  1  memory transfer complete
- m_retry  in  1  memory busy, re-issue
- grant  out  2  one-hot owner, bit0=I, bit1=D
- busy  out  1  a grant is held

Behaviour:
- Request: x_req = x_cyc & x_stb.
- States: IDLE, GRANT_I, GRANT_D (registered). Also registered: last_grant (1 bit), beat_cnt ($clog2(MAX_BEATS+1) bits).
- Reset (async, rst_n=0):
  - state=IDLE, last_grant=I (so D wins the first tie), beat_cnt=0.
  - All m_* outputs, x_resp, x_retry, grant and busy are 0 immediately.
  - Any memory transfer in flight is abandoned.
- IDLE:
  - m_cyc, m_stb and all responses are 0.
  - Exactly one x_req: GRANT_x on the next edge.
  - Both x_req: grant the side opposite last_grant.
  - Arbitration latency is one cycle.
- GRANT_x:
  - m_cyc, m_stb, m_we, m_sel, m_addr and m_wdata pass combinationally from side x.
  - x_resp = m_resp. x_retry = m_retry & ~m_resp; resp wins when both assert.
  - Non-granted side: resp=0, retry=0. It simply waits with its request held.
  - m_rdata is broadcast to both x_rdata and is valid only when qualified by x_resp.
  - grant = onehot(x). busy = 1.
  - beat_cnt increments on each m_resp and saturates at MAX_BEATS. m_retry never counts and never releases ownership.
- Release: next-state arbitration runs on the edge where any of the following holds:
  - (a) x_cyc = 0;
  - (b) MAX_BEATS ≠ 0, and m_resp is asserted with beat_cnt+1 ≥ MAX_BEATS, and the other side's req = 1.
- Release handling:
  - last_grant ← x and beat_cnt ← 0.
  - If the other side has req, the next state is GRANT_other (zero idle cycles). Otherwise the next state is IDLE.
  - Under (b) with x_cyc still high, x re-enters arbitration as an ordinary waiting requester.
- Preemption occurs only on a beat boundary (m_resp cycle), so a strobe is never withdrawn while outstanding at memory.
- Protocol errors:
  - Holder drops cyc while its strobe is outstanding: ownership is released anyway and the late m_resp is dropped.
  - Memory returns m_resp while IDLE: ignored.
- Width rules: the beat counter compare is unsigned. MAX_BEATS=1 hands off after every beat when both sides request.

Decomposition:
- lc3b_types additions:
  - enum lc3b_arb_state {ARB_IDLE, ARB_GRANT_I, ARB_GRANT_D}
  - constants ARB_SEL_I=0, ARB_SEL_D=1
  - reuse lc3b_word, lc3b_data, lc3b_mem_wmask
- Sub-module arb_beat_counter: saturating counter with clear, increment enable and an at_limit flag, parameterised by MAX_BEATS. The FSM and muxing stay in mem_port_arbiter.

Test Plan:
- Reset, then single request: i_cyc=i_stb=1, i_addr=0x1230 → grant=01 after 1 edge, m_addr=0x1230. m_resp held 1 cycle with m_rdata=0xA5.. → i_resp=1, i_rdata=0xA5.. that cycle, d_resp=0.
- Tie after reset: both requests raised on the same cycle → D granted first (grant=10). D drops cyc → grant=01 on the very next edge, with no IDLE cycle.
- Preemption with MAX_BEATS=4: D streams with cyc held and I waiting → after the 4th d_resp, grant switches to 01 next edge. With I idle, D keeps grant past 4 beats and beat_cnt stays at 4.
- Retry: memory asserts m_retry for 3 cycles, then m_resp → d_retry=1 for 3 cycles, grant stays 10 throughout, beat_cnt advances by 1 only. m_resp and m_retry asserted together → d_retry=0, d_resp=1.
- Async reset mid-transfer: rst_n=0 while GRANT_D with a strobe outstanding → m_cyc, m_stb, grant and busy go to 0 without a clock edge. After release, a simultaneous request again grants D first.
- MAX_BEATS=0: both sides requesting, D holds for 10 beats → no preemption. Grant changes only when d_cyc falls.
